// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares one external memory bus between the instruction-cache refill port
// and the data-side port. A transaction is a single word or a 4-beat burst.
// The winning request is latched into the o_mem_* registers, and the grant
// is held until the final beat is acknowledged. Per-beat acks go straight
// back to the owner in the same cycle. Read data is broadcast to both sides.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   - on simultaneous requests, the side not granted last wins.
//   undefined - fixed priority, with the data side ahead of the instruction side.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_ireq/i_iaddr/i_iburst4                     instruction request (read only)
//   o_iack/o_idata                               instruction per-beat ack, read data
//   i_dreq/i_daddr/i_dwe/i_dwdata/i_dburst4      data request
//   o_dack/o_ddata                               data per-beat ack, read data
//   o_mem_req/o_mem_addr/o_mem_we/o_mem_wdata/o_mem_burst4  latched memory request
//   i_mem_ack/i_mem_data                         memory per-beat ack, read data

module mem_bus_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,

  input  logic          i_ireq,
  input  logic [AW-1:0] i_iaddr,
  input  logic          i_iburst4,
  output logic          o_iack,
  output logic [DW-1:0] o_idata,

  input  logic          i_dreq,
  input  logic [AW-1:0] i_daddr,
  input  logic          i_dwe,
  input  logic [DW-1:0] i_dwdata,
  input  logic          i_dburst4,
  output logic          o_dack,
  output logic [DW-1:0] o_ddata,

  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_burst4,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  logic [1:0] state;
  logic [1:0] beat_cnt;
  logic       grant_d;
  logic       any_req;
  logic       final_beat;

  assign any_req = i_ireq | i_dreq;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the data side. Its reset value
  // means "data went last", so the instruction side wins the first tie.
  logic last_was_d;

  // When both sides request, the side that did not win last time gets the bus.
  assign grant_d = i_dreq & (~i_ireq | ~last_was_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_was_d <= 1'b1;
    end else if (state == ST_IDLE && any_req) begin
      last_was_d <= grant_d;
    end
  end
`else
  assign grant_d = i_dreq;
`endif

  // A single transfer ends on its first ack. A burst ends on the ack that
  // arrives while the counter already reads 3.
  assign final_beat = i_mem_ack & (~o_mem_burst4 | (beat_cnt == 2'd3));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      beat_cnt     <= 2'd0;
      o_mem_req    <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_wdata  <= '0;
      o_mem_burst4 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Acks that arrive while idle are dropped here.
          if (any_req) begin
            state        <= grant_d ? ST_BUSY_D : ST_BUSY_I;
            beat_cnt     <= 2'd0;
            o_mem_req    <= 1'b1;
            o_mem_addr   <= grant_d ? i_daddr : i_iaddr;
            o_mem_we     <= grant_d & i_dwe;
            o_mem_wdata  <= grant_d ? i_dwdata : '0;
            o_mem_burst4 <= grant_d ? i_dburst4 : i_iburst4;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // Requesters dropping req mid-transaction are ignored. The
          // transfer always runs to its final beat.
          if (i_mem_ack) begin
            beat_cnt <= beat_cnt + 2'd1;
          end
          if (final_beat) begin
            state     <= ST_IDLE;
            o_mem_req <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_iack  = i_mem_ack & (state == ST_BUSY_I);
  assign o_dack  = i_mem_ack & (state == ST_BUSY_D);
  assign o_idata = i_mem_data;
  assign o_ddata = i_mem_data;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates a single external memory bus between the instruction-cache refill port and the data-side port. Each transaction is either a single word or a 4-beat burst. The block latches the winning request and drives the memory bus. It holds the grant until the final beat is acknowledged, then routes acks and read data back to the owner. It sits between `icache`/data-memory unit and the memory/Wishbone bridge.

## Interface
- `AW`, 16: address width (matches `RW`).
- `DW`, 32: data width (matches `I_SIZE`).
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_ireq` in 1: instruction-side request; read only.
- `i_iaddr` in AW: instruction-side address.
- `i_iburst4` in 1: instruction-side 4-beat burst.
- `o_iack` out 1: per-beat ack to instruction side.
- `o_idata` out DW: read data to instruction side.
- `i_dreq` in 1: data-side request.
- `i_daddr` in AW: data-side address.
- `i_dwe` in 1: data-side write enable.
- `i_dwdata` in DW: data-side write data.
- `i_dburst4` in 1: data-side burst; must be 0 when `i_dwe`=1.
- `o_dack` out 1: per-beat ack to data side.
- `o_ddata` out DW: read data to data side.
- `o_mem_req` out 1: memory request.
- `o_mem_addr` out AW: latched address.
- `o_mem_we` out 1: latched write enable.
- `o_mem_wdata` out DW: latched write data.
- `o_mem_burst4` out 1: latched burst flag.
- `i_mem_ack` in 1: per-beat ack from memory.
- `i_mem_data` in DW: read data from memory.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Samples `i_ireq` and `i_dreq` and picks a winner.
  - Latches the winner's addr, we, wdata and burst4 into the `o_mem_*` registers.
  - Sets `o_mem_req`=1 and the beat counter to 0.
  - Moves to BUSY_I or BUSY_D.
  - With no request it stays in IDLE.
- BUSY_x:
  - On each `i_mem_ack`, the counter increments (2-bit).
  - The final beat is the ack with counter==3 when burst, or the first ack when single.
  - On the final beat: `o_mem_req` goes to 0 and the state goes to IDLE.
- Ack/data routing:
  - `o_iack` = `i_mem_ack` & (state==BUSY_I), combinational.
  - `o_dack` = `i_mem_ack` & (state==BUSY_D), combinational.
  - `o_idata` and `o_ddata` both carry `i_mem_data`, unqualified.
- `o_mem_addr` is the unmodified base address for the whole burst; memory increments internally.
- Requester deasserting req mid-transaction: ignored. The transaction completes and acks are still forwarded.
- `i_mem_ack` in IDLE: ignored. It is not forwarded and no state changes.
- Priority when both request in IDLE: see Configuration. Only one requester: granted regardless of mode.
- Requester holding req after its final ack: re-arbitrated in the next IDLE cycle like any new request.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - `o_mem_req`=0, `o_mem_we`=0, `o_mem_burst4`=0.
  - `o_mem_addr`=0, `o_mem_wdata`=0.
  - `o_iack`=`o_dack`=0.
  - Round-robin pointer = data side last.
- Reset mid-burst: all of the above is cleared immediately (asynchronous). The partial burst is abandoned.
- Grant latency: req high before edge N gives `o_mem_req`=1 after edge N.
- Release: final ack during cycle M gives `o_mem_req`=0 after edge M. The state is IDLE in cycle M+1.
- Back-to-back: at least one IDLE cycle between transactions, so the minimum gap is 1 cycle of `o_mem_req`=0.
- Ack to requester: zero-cycle, same cycle as `i_mem_ack`.
- The `o_mem_*` fields are stable for the whole time `o_mem_req`=1.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, the side not granted last wins.
  - The pointer updates at every grant.
- Undefined:
  - Fixed priority, data side always wins over instruction side.
  - No pointer register exists.

## Test plan
- Single instruction burst:
  - Stimulus: `i_ireq`=1, addr 0x0124, burst4; memory acks on 4 consecutive cycles with data 0xA0..0xA3.
  - Response: `o_mem_addr`=0x0124 for all 4 beats; `o_iack` pulses 4 times carrying 0xA0..0xA3; `o_mem_req` drops after the 4th ack; `o_dack` never asserts.
- Data write single:
  - Stimulus: addr 0x0010, wdata 0xDEADBEEF, we=1; memory acks after 3 wait cycles.
  - Response: `o_mem_we`=1 and wdata held until the ack; one `o_dack` pulse; return to IDLE.
- Simultaneous requests, ireq and dreq both rising in the same cycle:
  - Response with macro: the first grant follows the pointer (instruction after reset); the next transaction serves data after one IDLE cycle.
  - Response without macro: data wins both times while both are held.
- Mid-burst request:
  - Stimulus: `i_dreq` asserts during beat 2 of an instruction burst.
  - Response: the burst finishes all 4 beats uninterrupted; the data grant follows one IDLE cycle later.
- Reset mid-burst:
  - Stimulus: `i_rst_n` low after 2 beats.
  - Response: `o_mem_req`=0 immediately without waiting for a clock; after release the next request starts with counter 0.
- Spurious ack:
  - Stimulus: `i_mem_ack`=1 while IDLE.
  - Response: no `o_iack`/`o_dack`; the state stays IDLE.
